parity_checker: RTL and testbench

Registered single-word parity checker. Each enabled cycle it samples a data word and its received parity bit and checks them against the configured parity sense (even or odd). It flags pass/fail one cycle later and keeps a saturating error count. It sits on the receive side of serial/parallel links, after deserialisation, to qualify incoming words.

---
 rtl/parity_pkg.sv | 17 +
 rtl/parity_tree.sv | 35 +++
 rtl/parity_checker.sv | 83 ++++++++
 tb/tb_parity_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity checker/generator family.
package parity_pkg;

   localparam int PARITY_EVEN = 0;
   localparam int PARITY_ODD  = 1;

   // Bit-serial reference reduction; the checker uses the balanced parity_tree instead.
   function automatic logic xor_reduce(input logic [63:0] data, input int unsigned width);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < width) r = r ^ data[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/parity_tree.sv
// Balanced XOR reduction of data_in plus parity_in; keeps depth at log2 for wide words.
module parity_tree
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  parity_in,
   output logic                  p_out
);

   localparam int NUM_BITS = DATA_WIDTH + 1;
   localparam int LEVELS   = $clog2(NUM_BITS);
   localparam int LEAVES   = 1 << LEVELS;

   // Heap layout: node i has children 2i+1 and 2i+2, leaves occupy the upper half.
   logic node [2*LEAVES-1];

   for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
      if (i < DATA_WIDTH) begin : g_data
         assign node[LEAVES-1+i] = data_in[i];
      end else if (i == DATA_WIDTH) begin : g_par
         assign node[LEAVES-1+i] = parity_in;
      end else begin : g_pad
         assign node[LEAVES-1+i] = 1'b0;
      end
   end

   for (genvar i = 0; i < LEAVES-1; i++) begin : g_node
      assign node[i] = node[2*i+1] ^ node[2*i+2];
   end

   assign p_out = node[0];

endmodule

// File: rtl/parity_checker.sv
// Registered parity checker: one-cycle pass/fail flags plus saturating error count.
module parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_TYPE = 0,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  parity_in,
   output logic                  valid_out,
   output logic                  error_out,
   output logic                  done_out,
   output logic [CNT_WIDTH-1:0]  err_count
);

   if (PARITY_TYPE != PARITY_EVEN && PARITY_TYPE != PARITY_ODD) begin : g_bad_parity_type
      $error("parity_checker: PARITY_TYPE must be 0 (even) or 1 (odd)");
   end
   if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_data_width
      $error("parity_checker: DATA_WIDTH must be 1..64");
   end
   if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
      $error("parity_checker: CNT_WIDTH must be 1..32");
   end

   localparam logic SENSE = (PARITY_TYPE == PARITY_ODD);

   logic                 p;
   logic                 pass;
   logic                 valid_d, valid_q;
   logic                 error_d, error_q;
   logic                 done_d,  done_q;
   logic [CNT_WIDTH-1:0] cnt_d,   cnt_q;

   parity_tree #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tree (
      .data_in   (data_in),
      .parity_in (parity_in),
      .p_out     (p)
   );

   assign pass = (p == SENSE);

   always_comb begin
      valid_d = valid_q;
      error_d = error_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      if (en) begin
         valid_d = pass;
         error_d = ~pass;
         done_d  = 1'b1;
         if (!pass && cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         error_q <= error_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_out = valid_q;
   assign error_out = error_q;
   assign done_out  = done_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_parity_checker.sv
// Directed bench for parity_checker: even/odd sense, hold, saturation, async reset, 1-bit width.
module tb_parity_checker;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // a: even, 8b, 16b count
   logic       en_a = 0, par_a = 0;
   logic [7:0] d_a = '0;
   logic       v_a, e_a, dn_a;
   logic [15:0] c_a;
   // b: odd, 8b
   logic       en_b = 0, par_b = 0;
   logic [7:0] d_b = '0;
   logic       v_b, e_b, dn_b;
   logic [15:0] c_b;
   // c: even, 8b, 2b count
   logic       en_c = 0, par_c = 0;
   logic [7:0] d_c = '0;
   logic       v_c, e_c, dn_c;
   logic [1:0] c_c;
   // d: even, 1b data
   logic       en_d = 0, par_d = 0;
   logic [0:0] d_d = '0;
   logic       v_d, e_d, dn_d;
   logic [15:0] c_d;

   int n_cmp = 0;
   int n_err = 0;

   parity_checker #(.DATA_WIDTH(8), .PARITY_TYPE(0), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .data_in(d_a), .parity_in(par_a),
      .valid_out(v_a), .error_out(e_a), .done_out(dn_a), .err_count(c_a));
   parity_checker #(.DATA_WIDTH(8), .PARITY_TYPE(1), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .data_in(d_b), .parity_in(par_b),
      .valid_out(v_b), .error_out(e_b), .done_out(dn_b), .err_count(c_b));
   parity_checker #(.DATA_WIDTH(8), .PARITY_TYPE(0), .CNT_WIDTH(2)) dut_c (
      .clk(clk), .rst(rst), .en(en_c), .data_in(d_c), .parity_in(par_c),
      .valid_out(v_c), .error_out(e_c), .done_out(dn_c), .err_count(c_c));
   parity_checker #(.DATA_WIDTH(1), .PARITY_TYPE(0), .CNT_WIDTH(16)) dut_d (
      .clk(clk), .rst(rst), .en(en_d), .data_in(d_d), .parity_in(par_d),
      .valid_out(v_d), .error_out(e_d), .done_out(dn_d), .err_count(c_d));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({v_a, e_a, dn_a, c_a} !== 19'd0) begin
         n_err++; $display("FAIL reset_a got v=%b e=%b d=%b c=%0d want all 0", v_a, e_a, dn_a, c_a);
      end
      n_cmp++;
      if ({v_c, e_c, dn_c, c_c} !== 5'd0) begin
         n_err++; $display("FAIL reset_c got v=%b e=%b d=%b c=%0d want all 0", v_c, e_c, dn_c, c_c);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({v_a, e_a, dn_a, c_a} !== 19'd0) begin
         n_err++; $display("FAIL reset_idle got v=%b e=%b d=%b c=%0d want all 0", v_a, e_a, dn_a, c_a);
      end
   endtask

   task automatic test_even();
      en_a = 1; d_a = 8'hFF; par_a = 1;
      tick();
      en_a = 0;
      n_cmp++;
      if ({v_a, e_a, dn_a} !== 3'b011 || c_a !== 16'd1) begin
         n_err++; $display("FAIL even_ff got v=%b e=%b d=%b c=%0d want v=0 e=1 d=1 c=1", v_a, e_a, dn_a, c_a);
      end
      tick();
      n_cmp++;
      if (dn_a !== 1'b0 || e_a !== 1'b1) begin
         n_err++; $display("FAIL even_pulse got d=%b e=%b want d=0 e=1", dn_a, e_a);
      end
      en_a = 1; d_a = 8'b0101_0100; par_a = 1;
      tick();
      en_a = 0;
      n_cmp++;
      if ({v_a, e_a, dn_a} !== 3'b101 || c_a !== 16'd1) begin
         n_err++; $display("FAIL even_pass got v=%b e=%b d=%b c=%0d want v=1 e=0 d=1 c=1", v_a, e_a, dn_a, c_a);
      end
   endtask

   task automatic test_hold();
      d_a = 8'h00; par_a = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         d_a = d_a ^ 8'h5A; par_a = ~par_a;
         n_cmp++;
         if ({v_a, e_a, dn_a} !== 3'b100 || c_a !== 16'd1) begin
            n_err++; $display("FAIL hold_%0d got v=%b e=%b d=%b c=%0d want v=1 e=0 d=0 c=1", i, v_a, e_a, dn_a, c_a);
         end
      end
   endtask

   task automatic test_odd();
      en_b = 1; d_b = 8'h00; par_b = 1;
      tick();
      n_cmp++;
      if ({v_b, e_b, dn_b} !== 3'b101 || c_b !== 16'd0) begin
         n_err++; $display("FAIL odd_pass got v=%b e=%b d=%b c=%0d want v=1 e=0 d=1 c=0", v_b, e_b, dn_b, c_b);
      end
      par_b = 0;
      tick();
      en_b = 0;
      n_cmp++;
      if ({v_b, e_b, dn_b} !== 3'b011 || c_b !== 16'd1) begin
         n_err++; $display("FAIL odd_fail got v=%b e=%b d=%b c=%0d want v=0 e=1 d=1 c=1", v_b, e_b, dn_b, c_b);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] dv [3] = '{8'h03, 8'h07, 8'h80};
      logic       pv [3] = '{1'b0, 1'b0, 1'b1};
      logic       ev [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] cv [3] = '{16'd1, 16'd2, 16'd2};
      en_a = 1;
      for (int i = 0; i < 3; i++) begin
         d_a = dv[i]; par_a = pv[i];
         tick();
         n_cmp++;
         if (v_a !== ev[i] || e_a !== ~ev[i] || dn_a !== 1'b1 || c_a !== cv[i]) begin
            n_err++; $display("FAIL b2b_%0d got v=%b e=%b d=%b c=%0d want v=%b d=1 c=%0d", i, v_a, e_a, dn_a, c_a, ev[i], cv[i]);
         end
      end
      en_a = 0;
      tick();
      n_cmp++;
      if (dn_a !== 1'b0 || v_a !== 1'b1 || c_a !== 16'd2) begin
         n_err++; $display("FAIL b2b_end got d=%b v=%b c=%0d want d=0 v=1 c=2", dn_a, v_a, c_a);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] cv [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      en_c = 1; d_c = 8'h01; par_c = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (c_c !== cv[i] || e_c !== 1'b1) begin
            n_err++; $display("FAIL sat_%0d got c=%0d e=%b want c=%0d e=1", i, c_c, e_c, cv[i]);
         end
      end
      d_c = 8'h01; par_c = 1;
      tick();
      en_c = 0;
      n_cmp++;
      if (v_c !== 1'b1 || c_c !== 2'd3) begin
         n_err++; $display("FAIL sat_pass got v=%b c=%0d want v=1 c=3", v_c, c_c);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({v_c, e_c, dn_c, c_c} !== 5'd0) begin
         n_err++; $display("FAIL async_rst got v=%b e=%b d=%b c=%0d want all 0", v_c, e_c, dn_c, c_c);
      end
      n_cmp++;
      if (v_a !== 1'b0 || c_a !== 16'd0 || c_b !== 16'd0) begin
         n_err++; $display("FAIL async_rst_ab got va=%b ca=%0d cb=%0d want 0", v_a, c_a, c_b);
      end
      tick();
      @(negedge clk);
      rst = 1'b1;
      en_c = 1; d_c = 8'h11; par_c = 0;
      tick();
      en_c = 0;
      n_cmp++;
      if ({v_c, e_c, dn_c} !== 3'b101 || c_c !== 2'd0) begin
         n_err++; $display("FAIL post_rst got v=%b e=%b d=%b c=%0d want v=1 e=0 d=1 c=0", v_c, e_c, dn_c, c_c);
      end
   endtask

   task automatic test_width1();
      en_d = 1; d_d = 1'b1; par_d = 1;
      tick();
      n_cmp++;
      if ({v_d, e_d} !== 2'b10 || c_d !== 16'd0) begin
         n_err++; $display("FAIL w1_pass got v=%b e=%b c=%0d want v=1 e=0 c=0", v_d, e_d, c_d);
      end
      par_d = 0;
      tick();
      en_d = 0;
      n_cmp++;
      if ({v_d, e_d} !== 2'b01 || c_d !== 16'd1) begin
         n_err++; $display("FAIL w1_fail got v=%b e=%b c=%0d want v=0 e=1 c=1", v_d, e_d, c_d);
      end
   endtask

   initial begin
      test_reset();
      test_even();
      test_hold();
      test_odd();
      test_back_to_back();
      test_saturate();
      test_width1();
      test_async_reset();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
